// File: rtl/vga_draw_arbiter_if.sv
// rtl/vga_draw_arbiter_if.sv - column-side and vga-side signal bundle for vga_draw_arbiter
//
// Ports carried (widths follow the parameters):
//   req, done, px_plot   N_COL          per-column request / last-pixel strobe / write enable
//   px_x, px_y, px_colour packed         column i field at [i*W +: W]
//   gnt                  N_COL          one-hot grant, zero when idle
//   vga_x/y/colour/plot                 registered pixel bus towards vga_adapter
//   busy, timeout_err                   arbiter status
// Modports: master = column FSMs side (drives requests and pixels),
//           slave  = arbiter side (drives grant, vga bus and status).

interface vga_draw_arbiter_if #(
    parameter int N_COL   = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic [N_COL-1:0]         req;
    logic [N_COL-1:0]         done;
    logic [N_COL*X_W-1:0]     px_x;
    logic [N_COL*Y_W-1:0]     px_y;
    logic [N_COL*COLOR_W-1:0] px_colour;
    logic [N_COL-1:0]         px_plot;
    logic [N_COL-1:0]         gnt;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    logic [COLOR_W-1:0]       vga_colour;
    logic                     vga_plot;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output req, done, px_x, px_y, px_colour, px_plot,
        input  gnt, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
    );

    modport slave (
        input  req, done, px_x, px_y, px_colour, px_plot,
        output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin owner of the single vga_adapter pixel-write port
//
// Ports:
//   CLOCK_50   in  system clock, rising edge
//   reset      in  synchronous reset, active-high
//   bus        slave modport of vga_draw_arbiter_if:
//                in  req/done/px_x/px_y/px_colour/px_plot from the column FSMs
//                out gnt (one-hot), vga_x/y/colour/plot (registered, 1 cycle latency),
//                    busy, timeout_err (sticky until reset)

module vga_draw_arbiter #(
    parameter int N_COL    = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int MAX_HOLD = 4096
) (
    input logic               CLOCK_50,
    input logic               reset,
    vga_draw_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int IDX_W = (N_COL > 1) ? $clog2(N_COL) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] owner_next;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    int               cand;

    // First requester at or above the pointer, wrapping round.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < N_COL; k++) begin
            cand = (int'(ptr) + k) % N_COL;
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Pointer moves past the releasing owner so it goes to the back of the queue.
    assign owner_next = (int'(owner) == N_COL - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            owner           <= '0;
            hold_cnt        <= '0;
            bus.gnt         <= '0;
            bus.vga_x       <= '0;
            bus.vga_y       <= '0;
            bus.vga_colour  <= '0;
            bus.vga_plot    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.vga_plot <= 1'b0;
                    if (pick_valid) begin
                        state    <= BUSY;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        bus.gnt  <= {{(N_COL-1){1'b0}}, 1'b1} << pick_idx;
                        bus.busy <= 1'b1;
                    end
                end
                BUSY: begin
                    // The pixel on the releasing edge is still forwarded.
                    bus.vga_x      <= bus.px_x[owner*X_W +: X_W];
                    bus.vga_y      <= bus.px_y[owner*Y_W +: Y_W];
                    bus.vga_colour <= bus.px_colour[owner*COLOR_W +: COLOR_W];
                    bus.vga_plot   <= bus.px_plot[owner];
                    // done/abandon are checked before the hold limit, so a done
                    // landing on the limit edge releases without an error.
                    if (bus.done[owner] || !bus.req[owner]) begin
                        state    <= IDLE;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        ptr      <= owner_next;
                    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state           <= IDLE;
                        bus.gnt         <= '0;
                        bus.busy        <= 1'b0;
                        ptr             <= owner_next;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - scoreboard bench for vga_draw_arbiter against a behavioural model

module tb_vga_draw_arbiter;
    localparam int N_COL    = 4;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;
    localparam int MAX_HOLD = 8;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    vga_draw_arbiter_if #(.N_COL(N_COL), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

    vga_draw_arbiter #(
        .N_COL(N_COL), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic       err;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] pix_q[$];
    logic [3:0]  got_order[$];

    int checks = 0;
    int errors = 0;
    bit t3_rec = 0;

    // Reference model: who owns the port, how long it has held it, where the
    // round-robin search starts next, and the last pixel sent to the adapter.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_age   = 0;
    bit         m_err   = 0;
    logic [7:0] m_x     = '0;
    logic [6:0] m_y     = '0;
    logic [2:0] m_c     = '0;
    bit         m_plot  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [3:0] r, d, p,
                              input logic [31:0] xs, input logic [27:0] ys, input logic [11:0] cs);
        exp_t e;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_err = 0;
            m_x = '0; m_y = '0; m_c = '0; m_plot = 0;
        end else if (m_owner < 0) begin
            m_plot = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i;
                    m_age   = 0;
                end
            end
        end else begin
            int g;
            bit rel;
            g = m_owner;
            m_x = xs[g*8 +: 8];
            m_y = ys[g*7 +: 7];
            m_c = cs[g*3 +: 3];
            m_plot = p[g];
            rel = 0;
            if (d[g] || !r[g]) rel = 1;
            else if (m_age == MAX_HOLD - 1) begin
                rel = 1;
                m_err = 1;
            end else m_age++;
            if (rel) begin
                m_ptr = (g + 1) % 4;
                m_owner = -1;
            end
        end
        e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.busy = (m_owner >= 0);
        e.err  = m_err;
        e.plot = m_plot;
        e.x = m_x; e.y = m_y; e.c = m_c;
        exp_q.push_back(e);
        if (m_plot) pix_q.push_back({m_x, m_y, m_c});
    endtask

    task automatic apply(input logic rst, input logic [3:0] r, d, p,
                         input logic [31:0] xs, input logic [27:0] ys, input logic [11:0] cs);
        @(negedge CLOCK_50);
        reset         = rst;
        bus.req       = r;
        bus.done      = d;
        bus.px_plot   = p;
        bus.px_x      = xs;
        bus.px_y      = ys;
        bus.px_colour = cs;
        model_step(rst, r, d, p, xs, ys, cs);
    endtask

    task automatic apply_rand_reset();
        apply(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), $urandom, 28'($urandom), 12'($urandom));
    endtask

    // Behaves like the column FSMs: the owning column (per the model) plots
    // every cycle and raises done on its burst-th pixel (never if burst==0).
    // Columns in 'noisy' drive plot=1/done=1 whenever they do not own the port.
    task automatic run_cols(input int cycles, input logic [3:0] rmask, input int burst,
                            input logic [3:0] noisy);
        int cnt;
        int last_owner;
        cnt = 0;
        last_owner = -1;
        for (int n = 0; n < cycles; n++) begin
            logic [3:0]  d, p;
            logic [31:0] xs;
            logic [27:0] ys;
            logic [11:0] cs;
            xs = $urandom; ys = 28'($urandom); cs = 12'($urandom);
            p = noisy;
            d = noisy;
            if (m_owner >= 0) begin
                if (m_owner != last_owner) cnt = 0;
                p[m_owner] = 1'b1;
                d[m_owner] = 1'b0;
                cnt++;
                if (burst > 0 && cnt == burst) d[m_owner] = 1'b1;
            end
            last_owner = m_owner;
            apply(1'b0, rmask, d, p, xs, ys, cs);
        end
    endtask

    // Monitor: compares every post-edge output against the scoreboard and
    // pops the pixel queue whenever the adapter sees a write.
    initial begin
        logic [3:0] prev_gnt;
        exp_t e;
        logic [17:0] px;
        prev_gnt = '0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", int'(bus.gnt), int'(e.gnt));
                check("busy", int'(bus.busy), int'(e.busy));
                check("timeout_err", int'(bus.timeout_err), int'(e.err));
                check("vga_plot", int'(bus.vga_plot), int'(e.plot));
                check("vga_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), int'({e.x, e.y, e.c}));
                if (bus.vga_plot === 1'b1) begin
                    if (pix_q.size() == 0) check("pixel_unexpected", 1, 0);
                    else begin
                        px = pix_q.pop_front();
                        check("pixel", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), int'(px));
                    end
                end
            end
            if (t3_rec && bus.gnt != prev_gnt && bus.gnt != 4'b0000) begin
                if (prev_gnt != 4'b0000) check("grant_gap", int'(prev_gnt), 0);
                got_order.push_back(bus.gnt);
            end
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        logic [3:0]  t3_exp[5];
        logic [31:0] xs;
        logic [27:0] ys;
        logic [11:0] cs;
        t3_exp[0] = 4'b0001; t3_exp[1] = 4'b0010; t3_exp[2] = 4'b0100;
        t3_exp[3] = 4'b1000; t3_exp[4] = 4'b0001;
        bus.req = '0; bus.done = '0; bus.px_plot = '0;
        bus.px_x = '0; bus.px_y = '0; bus.px_colour = '0;

        // T1: reset with random inputs
        repeat (3) apply_rand_reset();

        // T2: single burst from column 2
        xs = '0; ys = '0; cs = '0;
        xs[16 +: 8] = 8'd10; ys[14 +: 7] = 7'd20; cs[6 +: 3] = 3'd7;
        apply(1'b0, 4'b0100, 4'b0000, 4'b0000, xs, ys, cs);
        apply(1'b0, 4'b0100, 4'b0000, 4'b0100, xs, ys, cs);
        xs[16 +: 8] = 8'd11;
        apply(1'b0, 4'b0100, 4'b0000, 4'b0100, xs, ys, cs);
        xs[16 +: 8] = 8'd12;
        apply(1'b0, 4'b0100, 4'b0100, 4'b0100, xs, ys, cs);
        apply(1'b0, 4'b0000, 4'b0000, 4'b0000, xs, ys, cs);
        apply(1'b0, 4'b0000, 4'b0000, 4'b0000, xs, ys, cs);

        // T3: all columns requesting from reset, 2-pixel bursts
        apply_rand_reset();
        t3_rec = 1;
        run_cols(13, 4'b1111, 2, 4'b0000);
        @(posedge CLOCK_50);
        #2;
        t3_rec = 0;
        check("t3_grant_count", got_order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_order.size()) check($sformatf("t3_grant%0d", i), int'(got_order[i]), int'(t3_exp[i]));
        end

        // T4: column 3 spams plot/done while column 0 owns the port
        apply_rand_reset();
        run_cols(16, 4'b1001, 0, 4'b1000);

        // T5: hold limit with another request pending
        apply_rand_reset();
        run_cols(24, 4'b0110, 0, 4'b0000);
        run_cols(4, 4'b0000, 0, 4'b0000);

        // T6: reset in the middle of column 1's burst
        apply_rand_reset();
        run_cols(4, 4'b0010, 0, 4'b0000);
        apply_rand_reset();
        run_cols(10, 4'b1010, 3, 4'b0000);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 59) == 0, 4'($urandom), 4'($urandom_range(0, 15) & $urandom),
                  4'($urandom), $urandom, 28'($urandom), 12'($urandom));
        end
        run_cols(60, 4'b1111, 5, 4'b0101);

        @(posedge CLOCK_50);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
